// File: rtl/muldiv_seq.sv
// Iterative MIPS multiply/divide unit owning HI/LO. One shared 33-bit adder
// does shift-add multiply and restoring divide over WIDTH iterations.
module muldiv_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic             sign,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_FIX = 2'd2} state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 is_div_q, is_div_d;
  logic                 neg_lo_q, neg_lo_d;
  logic                 neg_hi_q, neg_hi_d;
  logic                 zero_q, zero_d;
  logic [WIDTH-1:0]     opnd_q, opnd_d;
  logic [WIDTH-1:0]     raw_q, raw_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 dbz_q, dbz_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;

  logic [WIDTH:0]       add_a, add_b;
  logic                 add_cin;
  logic [WIDTH+1:0]     add_sum;
  logic                 q_bit;
  logic [WIDTH-1:0]     rem_next;
  logic [2*WIDTH-1:0]   prod_fix;
  logic [WIDTH-1:0]     quo_fix, rem_fix;

  function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] v, input logic s);
    return (s && v[WIDTH-1]) ? -v : v;
  endfunction

  // Shared adder: divide subtracts the divisor from the shifted remainder,
  // multiply conditionally adds the multiplicand to the upper half.
  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    if (is_div_q) begin
      add_a   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
      add_b   = ~{1'b0, opnd_q};
      add_cin = 1'b1;
    end else begin
      add_a   = {1'b0, acc_q[2*WIDTH-1:WIDTH]};
      add_b   = acc_q[0] ? {1'b0, opnd_q} : '0;
      add_cin = 1'b0;
    end
  end

  assign add_sum  = {1'b0, add_a} + {1'b0, add_b} + {{(WIDTH+1){1'b0}}, add_cin};
  // Carry out of the subtract is the inverted borrow, i.e. the quotient bit.
  assign q_bit    = add_sum[WIDTH+1];
  assign rem_next = q_bit ? add_sum[WIDTH-1:0] : add_a[WIDTH-1:0];
  assign prod_fix = neg_lo_q ? -acc_q : acc_q;
  assign quo_fix  = neg_lo_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign rem_fix  = neg_hi_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    zero_d   = zero_q;
    opnd_d   = opnd_q;
    raw_d    = raw_q;
    acc_d    = acc_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    dbz_d    = 1'b0;
    hi_d     = hi_q;
    lo_d     = lo_q;
    case (state_q)
      S_IDLE: begin
        if (start && (op[1] == 1'b0)) begin
          state_d  = S_RUN;
          busy_d   = 1'b1;
          cnt_d    = '0;
          is_div_d = op[0];
          raw_d    = in1;
          zero_d   = op[0] && (in2 == '0);
          neg_lo_d = sign && (in1[WIDTH-1] ^ in2[WIDTH-1]);
          if (op[0]) begin
            opnd_d   = abs_val(in2, sign);
            acc_d    = {{WIDTH{1'b0}}, abs_val(in1, sign)};
            neg_hi_d = sign && in1[WIDTH-1];
          end else begin
            opnd_d   = abs_val(in1, sign);
            acc_d    = {{WIDTH{1'b0}}, abs_val(in2, sign)};
            neg_hi_d = 1'b0;
          end
        end else if (start) begin
          if (op[0]) begin
            lo_d = in1;
          end else begin
            hi_d = in1;
          end
        end else begin
          busy_d = 1'b0;
        end
      end
      S_RUN: begin
        if (is_div_q) begin
          acc_d = {rem_next, acc_q[WIDTH-2:0], q_bit};
        end else begin
          acc_d = {add_sum[WIDTH:0], acc_q[WIDTH-1:1]};
        end
        if (cnt_q == CNT_W'(WIDTH-1)) begin
          state_d = S_FIX;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      S_FIX: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        dbz_d   = zero_q;
        if (!is_div_q) begin
          {hi_d, lo_d} = prod_fix;
        end else if (zero_q) begin
          hi_d = raw_q;
          lo_d = {WIDTH{1'b1}};
        end else begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset discards any in-flight operation.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      zero_q   <= 1'b0;
      opnd_q   <= '0;
      raw_q    <= '0;
      acc_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      zero_q   <= zero_d;
      opnd_q   <= opnd_d;
      raw_q    <= raw_d;
      acc_q    <= acc_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      dbz_q    <= dbz_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq: expected HI/LO/flag pushed at issue,
// popped and compared when done pulses.
module tb_muldiv_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic        sign;
  logic [31:0] in1, in2;
  logic        busy, done, div_by_zero;
  logic [31:0] hi, lo;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
  } exp_t;
  exp_t sb[$];

  muldiv_seq #(.WIDTH(32), .CNT_W(6)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .sign(sign),
    .in1(in1), .in2(in2), .busy(busy), .done(done),
    .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] o, input logic s, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; op = o; sign = s; in1 = a; in2 = b;
    tick();
    start = 1'b0; in1 = $urandom; in2 = $urandom; sign = $urandom_range(0, 1);
  endtask

  task automatic push_exp(input logic [31:0] eh, input logic [31:0] el, input logic ed);
    exp_t e;
    e.hi = eh; e.lo = el; e.dbz = ed;
    sb.push_back(e);
  endtask

  // Waits for done with a cycle budget, then checks latency, busy length and result.
  task automatic finish_md(input string tag, input int edges0, input int busy0);
    int   edges;
    int   bc;
    exp_t e;
    edges = edges0;
    bc    = busy0;
    while (!done && edges < 60) begin
      tick();
      edges++;
      if (busy) bc++;
    end
    if (!done) begin
      check({tag, "_timeout"}, 64'd0, 64'd1);
    end else begin
      check({tag, "_latency"}, 64'(edges), 64'd34);
      check({tag, "_busy_cycles"}, 64'(bc), 64'd33);
      e = sb.pop_front();
      check({tag, "_hi"}, {32'd0, hi}, {32'd0, e.hi});
      check({tag, "_lo"}, {32'd0, lo}, {32'd0, e.lo});
      check({tag, "_dbz"}, {63'd0, div_by_zero}, {63'd0, e.dbz});
      tick();
      check({tag, "_done_pulse"}, {62'd0, done, div_by_zero}, 64'd0);
    end
  endtask

  task automatic run_md(input string tag, input logic [1:0] o, input logic s,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eh, input logic [31:0] el, input logic ed);
    push_exp(eh, el, ed);
    issue(o, s, a, b);
    check({tag, "_busy_after_e0"}, {63'd0, busy}, 64'd1);
    finish_md(tag, 1, busy ? 1 : 0);
  endtask

  initial begin
    int edges;
    int bc;
    int dcount;
    reset = 1'b1; start = 1'b0; op = 2'b00; sign = 1'b0; in1 = '0; in2 = '0;
    #3;
    check("reset_ctrl", {61'd0, busy, done, div_by_zero}, 64'd0);
    check("reset_hilo", {hi, lo}, 64'd0);
    tick();
    reset = 1'b0;
    tick();

    run_md("mult_neg3x5",  2'b00, 1'b1, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0);
    run_md("multu_max",    2'b00, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0);
    run_md("mult_m1xm1",   2'b00, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0);
    run_md("div_m7d2",     2'b01, 1'b1, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
    run_md("divu_100d7",   2'b01, 1'b0, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0);
    run_md("divu_by0",     2'b01, 1'b0, 32'h00000064, 32'd0,        32'h00000064, 32'hFFFFFFFF, 1'b1);
    run_md("div_by0_neg",  2'b01, 1'b1, 32'hFFFFFFF0, 32'd0,        32'hFFFFFFF0, 32'hFFFFFFFF, 1'b1);
    run_md("div_ovf",      2'b01, 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0);

    // MTHI / MTLO: one-edge writes, never busy, no done.
    issue(2'b10, 1'b0, 32'h12345678, 32'd0);
    check("mthi_hi", {32'd0, hi}, {32'd0, 32'h12345678});
    check("mthi_ctrl", {62'd0, busy, done}, 64'd0);
    issue(2'b11, 1'b0, 32'h9ABCDEF0, 32'd0);
    check("mtlo_lo", {32'd0, lo}, {32'd0, 32'h9ABCDEF0});
    check("mtlo_hi_kept", {32'd0, hi}, {32'd0, 32'h12345678});
    check("mtlo_ctrl", {62'd0, busy, done}, 64'd0);

    // MULT with an MTHI attempt at cycle 10 that must be ignored.
    push_exp(32'd0, 32'd12, 1'b0);
    issue(2'b00, 1'b0, 32'd3, 32'd4);
    edges = 1;
    bc    = busy ? 1 : 0;
    for (int i = 0; i < 9; i++) begin
      tick();
      edges++;
      if (busy) bc++;
    end
    start = 1'b1; op = 2'b10; in1 = 32'hDEADBEEF;
    tick();
    start = 1'b0;
    edges++;
    if (busy) bc++;
    check("poke_hi_unchanged", {32'd0, hi}, {32'd0, 32'h12345678});
    check("poke_busy", {63'd0, busy}, 64'd1);
    finish_md("mult_poked", edges, bc);
    check("after_poke_hi", {32'd0, hi}, 64'd0);

    // Reset mid-divide at cycle 15: result discarded, done never pulses.
    issue(2'b01, 1'b0, 32'd100, 32'd7);
    for (int i = 0; i < 14; i++) tick();
    check("pre_rst_busy", {63'd0, busy}, 64'd1);
    reset = 1'b1;
    #1;
    check("rst_mid_ctrl", {61'd0, busy, done, div_by_zero}, 64'd0);
    check("rst_mid_hilo", {hi, lo}, 64'd0);
    tick();
    reset = 1'b0;
    dcount = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done || busy) dcount++;
    end
    check("rst_no_done", 64'(dcount), 64'd0);

    run_md("mult_6x7", 2'b00, 1'b0, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0);

    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
- Iterative multiply/divide unit for the 32-bit MIPS core.
- Executes MULT/MULTU/DIV/DIVU over multiple cycles using one shared 33-bit add/subtract path, and owns the architectural HI/LO registers.
- Also services MTHI/MTLO writes.
- Sits beside the single-cycle ALU. The control unit issues a start pulse and stalls the pipeline while busy is high.

Parameters:
WIDTH, 32, operand/result width of in1, in2, hi, lo
CNT_W, 6, iteration counter width (must hold WIDTH)

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
start  input  1  request; sampled only in IDLE
op  input  2  00 multiply, 01 divide, 10 write HI, 11 write LO
sign  input  1  1 = signed (MULT/DIV), 0 = unsigned (MULTU/DIVU); ignored for op 1x
in1  input  WIDTH  multiplicand / dividend / MTHI-MTLO data
in2  input  WIDTH  multiplier / divisor
busy  output  1  operation in progress; start ignored while high
done  output  1  one-cycle pulse when HI/LO updated by mul/div
div_by_zero  output  1  one-cycle pulse coincident with done for divide by zero
hi  output  WIDTH  HI register
lo  output  WIDTH  LO register

Behaviour:
- Reset (async, any time, including mid-operation):
  - Outputs: hi=0, lo=0, busy=0, done=0, div_by_zero=0.
  - State returns to IDLE; counter=0; the in-flight result is discarded.
- States:
  - IDLE -> RUN on start with op 0x.
  - RUN -> FIX after WIDTH iterations.
  - FIX -> IDLE.
- Accept edge E0 (IDLE, start=1, op=0x):
  - Latch sign and op.
  - Latch |in1| and |in2| when sign=1; raw values when sign=0.
  - Record the result-sign flags.
  - busy=1 after E0.
  - Inputs are don't-care after E0.
- RUN, edges E1..E32:
  - One iteration per edge on the shared 33-bit adder.
  - Multiply: shift-add, 64-bit product accumulator.
  - Divide: restoring shift-subtract, 33-bit partial remainder; the quotient bit is the inverted borrow.
  - Counter increments 0..31. The last iteration is at count 31; the next state is FIX.
- FIX, edge E33:
  - Multiply: two's-complement the 64-bit product if the signs differ.
  - Divide: negate the quotient if the operand signs differ; negate the remainder if the dividend is negative. Quotient truncates toward zero.
  - Write hi/lo at E33.
  - After E33: busy=0, done=1 for exactly one cycle.
  - Total: busy high 33 cycles. A new start is accepted at the edge where done=1.
- Results:
  - Multiply: {hi,lo} = full 64-bit product.
  - Divide: lo = quotient, hi = remainder.
- Divide by zero (in2==0):
  - Still runs all 33 cycles.
  - Result: hi=in1 as latched (unsigned raw / signed original value), lo=32'hFFFFFFFF.
  - div_by_zero pulses with done.
- Signed overflow, 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0, no flag.
- MTHI/MTLO (op 1x, IDLE, start=1):
  - hi (op 10) or lo (op 11) = in1 at E0.
  - busy stays 0; done not asserted.
- start while busy: ignored entirely, no queuing; hi/lo unaffected.
- hi/lo change only at a FIX edge, an MTHI/MTLO edge, or reset.

Test Plan:
- Reset, then MULT sign=1, in1=0xFFFFFFFD (-3), in2=5 -> done exactly 34 cycles after the start cycle; hi=0xFFFFFFFF, lo=0xFFFFFFF1; busy high 33 cycles.
- MULTU in1=in2=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; the same operands with sign=1 -> hi=0, lo=1.
- DIV sign=1, in1=0xFFFFFFF9 (-7), in2=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU 100/7 -> lo=14, hi=2.
- DIVU in1=0x64, in2=0 -> hi=0x64, lo=0xFFFFFFFF, div_by_zero=1 together with done; DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0, no flag.
- MTHI 0x12345678 then MTLO 0x9ABCDEF0 -> hi/lo updated the next cycle, busy never rises; then start a MULT and pulse start again with op=10 at cycle 10 -> ignored, hi unchanged until FIX.
- Reset asserted at cycle 15 of a DIV -> immediately busy=0, hi=lo=0; done never pulses; a new MULT 6*7 started after release -> lo=42, hi=0.
